// File: rtl/pipe_run_monitor.sv
// Run/retire monitor for the Y86 pipeline, observing the W stage.
// Counts RUN cycles, AOK retirements and bubbles, latches the first faulting
// status (or a no-retire watchdog timeout), drains for DRAIN_CYC cycles and
// then holds a sticky done until reboot.
module pipe_run_monitor #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned DRAIN_CYC = 1
) (
  input  logic             clk,
  input  logic             reboot_n,
  input  logic             start,
  input  logic             W_valid,
  input  logic [3:0]       W_icode,
  input  logic [1:0]       W_stat,
  output logic             running,
  output logic             done,
  output logic [1:0]       final_stat,
  output logic [3:0]       stop_icode,
  output logic [1:0]       stop_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  // Last watchdog value before a stop; unused when the watchdog is disabled.
  localparam longint unsigned TimeoutLast = (TIMEOUT == 0) ? 0 : longint'(TIMEOUT) - 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cycle_cnt_q;
  logic [CNT_W-1:0]   instr_cnt_q;
  logic [CNT_W-1:0]   bubble_cnt_q;
  logic [CNT_W-1:0]   wd_cnt_q;
  logic [DrainW-1:0]  drain_q;
  logic [1:0]         final_stat_q;
  logic [3:0]         stop_icode_q;
  logic [1:0]         stop_cause_q;

  logic   retire;
  logic   stat_stop;
  logic   wd_hit;
  logic   any_stop;
  state_e stop_state;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Decode this cycle's W-stage event and whether it ends the run.
  always_comb begin
    retire     = W_valid && (W_stat == 2'd0);
    stat_stop  = W_valid && (W_stat != 2'd0);
    wd_hit     = (TIMEOUT != 0) && (64'(wd_cnt_q) == 64'(TimeoutLast));
    any_stop   = stat_stop || (wd_hit && !retire);
    stop_state = (DRAIN_CYC == 0) ? StDone : StDrain;
  end

  // Run-control FSM together with all counters and latched stop information.
  always_ff @(posedge clk or negedge reboot_n) begin
    if (!reboot_n) begin
      state_q      <= StIdle;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      wd_cnt_q     <= '0;
      drain_q      <= '0;
      final_stat_q <= 2'd0;
      stop_icode_q <= 4'd0;
      stop_cause_q <= 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StRun;
            cycle_cnt_q  <= '0;
            instr_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            wd_cnt_q     <= '0;
            drain_q      <= '0;
            final_stat_q <= 2'd0;
            stop_icode_q <= 4'd0;
            stop_cause_q <= 2'd0;
          end
        end
        StRun: begin
          cycle_cnt_q <= sat_inc(cycle_cnt_q);
          if (retire) begin
            instr_cnt_q <= sat_inc(instr_cnt_q);
            wd_cnt_q    <= '0;
          end else begin
            wd_cnt_q <= sat_inc(wd_cnt_q);
          end
          if (!W_valid) begin
            bubble_cnt_q <= sat_inc(bubble_cnt_q);
          end
          if (any_stop) begin
            state_q      <= stop_state;
            drain_q      <= '0;
            stop_icode_q <= W_icode;
            // A faulting status outranks a simultaneous watchdog expiry.
            if (stat_stop) begin
              final_stat_q <= W_stat;
              stop_cause_q <= 2'd1;
            end else begin
              final_stat_q <= 2'd0;
              stop_cause_q <= 2'd2;
            end
          end
        end
        StDrain: begin
          if (drain_q == DrainW'(DRAIN_CYC - 1)) begin
            state_q <= StDone;
          end else begin
            drain_q <= drain_q + DrainW'(1);
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs come straight from state and registers.
  always_comb begin
    running    = (state_q == StRun);
    done       = (state_q == StDone);
    final_stat = final_stat_q;
    stop_icode = stop_icode_q;
    stop_cause = stop_cause_q;
    cycle_cnt  = cycle_cnt_q;
    instr_cnt  = instr_cnt_q;
    bubble_cnt = bubble_cnt_q;
  end

endmodule

// File: tb/tb_pipe_run_monitor.sv
// Scoreboard bench for pipe_run_monitor: four instances with different
// parameter sets share one W-stage stimulus stream. A sequence-level model
// predicts each instance's stop point and counts; monitors check on done rise.
module tb_pipe_run_monitor;

  localparam int NI = 4;

  typedef struct packed {
    logic [31:0] stop_n;
    logic [31:0] done_at;
    logic [1:0]  cause;
    logic [1:0]  fstat;
    logic [3:0]  icode;
    logic [31:0] cyc;
    logic [31:0] ins;
    logic [31:0] bub;
  } exp_t;

  logic       clk;
  logic       reboot_n;
  logic       start;
  logic       W_valid;
  logic [3:0] W_icode;
  logic [1:0] W_stat;

  logic        running_w [NI];
  logic        done_w    [NI];
  logic [1:0]  fstat_w   [NI];
  logic [3:0]  icode_w   [NI];
  logic [1:0]  cause_w   [NI];
  logic [31:0] cyc_w     [NI];
  logic [31:0] ins_w     [NI];
  logic [31:0] bub_w     [NI];

  logic [31:0] c0_cyc, c0_ins, c0_bub;
  logic [31:0] c1_cyc, c1_ins, c1_bub;
  logic [3:0]  c2_cyc, c2_ins, c2_bub;
  logic [7:0]  c3_cyc, c3_ins, c3_bub;

  int checks = 0;
  int errors = 0;

  // Per-run stimulus sequence, 1-based cycle index.
  logic       sv [64];
  logic [1:0] ss [64];
  logic [3:0] si [64];

  exp_t exp_q   [NI][$];
  exp_t cur_exp [NI];
  int   run_cyc    = 0;
  bit   run_active = 0;

  pipe_run_monitor #(.CNT_W(32), .TIMEOUT(16), .DRAIN_CYC(1)) u0 (
    .clk(clk), .reboot_n(reboot_n), .start(start), .W_valid(W_valid), .W_icode(W_icode),
    .W_stat(W_stat), .running(running_w[0]), .done(done_w[0]), .final_stat(fstat_w[0]),
    .stop_icode(icode_w[0]), .stop_cause(cause_w[0]), .cycle_cnt(c0_cyc), .instr_cnt(c0_ins),
    .bubble_cnt(c0_bub)
  );
  pipe_run_monitor #(.CNT_W(32), .TIMEOUT(4), .DRAIN_CYC(3)) u1 (
    .clk(clk), .reboot_n(reboot_n), .start(start), .W_valid(W_valid), .W_icode(W_icode),
    .W_stat(W_stat), .running(running_w[1]), .done(done_w[1]), .final_stat(fstat_w[1]),
    .stop_icode(icode_w[1]), .stop_cause(cause_w[1]), .cycle_cnt(c1_cyc), .instr_cnt(c1_ins),
    .bubble_cnt(c1_bub)
  );
  pipe_run_monitor #(.CNT_W(4), .TIMEOUT(0), .DRAIN_CYC(1)) u2 (
    .clk(clk), .reboot_n(reboot_n), .start(start), .W_valid(W_valid), .W_icode(W_icode),
    .W_stat(W_stat), .running(running_w[2]), .done(done_w[2]), .final_stat(fstat_w[2]),
    .stop_icode(icode_w[2]), .stop_cause(cause_w[2]), .cycle_cnt(c2_cyc), .instr_cnt(c2_ins),
    .bubble_cnt(c2_bub)
  );
  pipe_run_monitor #(.CNT_W(8), .TIMEOUT(6), .DRAIN_CYC(0)) u3 (
    .clk(clk), .reboot_n(reboot_n), .start(start), .W_valid(W_valid), .W_icode(W_icode),
    .W_stat(W_stat), .running(running_w[3]), .done(done_w[3]), .final_stat(fstat_w[3]),
    .stop_icode(icode_w[3]), .stop_cause(cause_w[3]), .cycle_cnt(c3_cyc), .instr_cnt(c3_ins),
    .bubble_cnt(c3_bub)
  );

  assign cyc_w[0] = c0_cyc;
  assign ins_w[0] = c0_ins;
  assign bub_w[0] = c0_bub;
  assign cyc_w[1] = c1_cyc;
  assign ins_w[1] = c1_ins;
  assign bub_w[1] = c1_bub;
  assign cyc_w[2] = 32'(c2_cyc);
  assign ins_w[2] = 32'(c2_ins);
  assign bub_w[2] = 32'(c2_bub);
  assign cyc_w[3] = 32'(c3_cyc);
  assign ins_w[3] = 32'(c3_ins);
  assign bub_w[3] = 32'(c3_bub);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end of run, expected finish");
    $fatal(1, "bench time limit");
  end

  function automatic int unsigned p_cw(int k);
    case (k)
      2:       return 4;
      3:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int unsigned p_to(int k);
    case (k)
      0:       return 16;
      1:       return 4;
      2:       return 0;
      default: return 6;
    endcase
  endfunction

  function automatic int unsigned p_dr(int k);
    case (k)
      1:       return 3;
      3:       return 0;
      default: return 1;
    endcase
  endfunction

  // Walk the sequence: the run ends at the first faulting instruction or at the
  // TIMEOUT-th consecutive cycle without a retirement; counts clip at 2^CNT_W-1.
  function automatic exp_t model(int k, int len);
    exp_t        e;
    longint      maxv;
    int unsigned to;
    int          streak;
    int          ins;
    int          bub;
    bit          ret;
    bit          flt;
    maxv   = (64'd1 << p_cw(k)) - 1;
    to     = p_to(k);
    streak = 0;
    ins    = 0;
    bub    = 0;
    e      = '0;
    for (int i = 1; i <= len; i++) begin
      ret = sv[i] && (ss[i] == 2'd0);
      flt = sv[i] && (ss[i] != 2'd0);
      if (!sv[i]) bub++;
      if (ret) begin
        ins++;
        streak = 0;
      end else begin
        streak++;
      end
      if (flt || (to != 0 && streak == int'(to) && (longint'(to) - 1) <= maxv)) begin
        e.stop_n  = 32'(i);
        e.done_at = 32'(i + int'(p_dr(k)));
        e.cause   = flt ? 2'd1 : 2'd2;
        e.fstat   = flt ? ss[i] : 2'd0;
        e.icode   = si[i];
        e.cyc     = 32'((longint'(i) < maxv) ? longint'(i) : maxv);
        e.ins     = 32'((longint'(ins) < maxv) ? longint'(ins) : maxv);
        e.bub     = 32'((longint'(bub) < maxv) ? longint'(bub) : maxv);
        return e;
      end
    end
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(int k);
    chk($sformatf("u%0d reset running", k), 64'(running_w[k]), 0);
    chk($sformatf("u%0d reset done", k), 64'(done_w[k]), 0);
    chk($sformatf("u%0d reset final_stat", k), 64'(fstat_w[k]), 0);
    chk($sformatf("u%0d reset stop_icode", k), 64'(icode_w[k]), 0);
    chk($sformatf("u%0d reset stop_cause", k), 64'(cause_w[k]), 0);
    chk($sformatf("u%0d reset cycle_cnt", k), 64'(cyc_w[k]), 0);
    chk($sformatf("u%0d reset instr_cnt", k), 64'(ins_w[k]), 0);
    chk($sformatf("u%0d reset bubble_cnt", k), 64'(bub_w[k]), 0);
  endtask

  // Monitors: running level every cycle, full result when done rises.
  for (genvar g = 0; g < NI; g++) begin : g_mon
    logic done_prev = 1'b0;
    always @(negedge clk) begin
      exp_t e;
      if (run_active) begin
        chk($sformatf("u%0d running @%0d", g, run_cyc), 64'(running_w[g]),
            64'(run_cyc < int'(cur_exp[g].stop_n)));
      end
      if (done_w[g] && !done_prev) begin
        if (exp_q[g].size() == 0) begin
          chk($sformatf("u%0d unexpected done", g), 64'(1), 64'(0));
        end else begin
          e = exp_q[g].pop_front();
          chk($sformatf("u%0d done cycle", g), 64'(run_cyc), 64'(e.done_at));
          chk($sformatf("u%0d stop_cause", g), 64'(cause_w[g]), 64'(e.cause));
          chk($sformatf("u%0d final_stat", g), 64'(fstat_w[g]), 64'(e.fstat));
          chk($sformatf("u%0d stop_icode", g), 64'(icode_w[g]), 64'(e.icode));
          chk($sformatf("u%0d cycle_cnt", g), 64'(cyc_w[g]), 64'(e.cyc));
          chk($sformatf("u%0d instr_cnt", g), 64'(ins_w[g]), 64'(e.ins));
          chk($sformatf("u%0d bubble_cnt", g), 64'(bub_w[g]), 64'(e.bub));
        end
      end
      done_prev = done_w[g];
    end
  end

  task automatic set_cyc(int i, logic v, logic [1:0] s, logic [3:0] ic);
    sv[i] = v;
    ss[i] = s;
    si[i] = ic;
  endtask

  task automatic junk();
    W_valid = 1'($urandom);
    W_stat  = 2'($urandom);
    W_icode = 4'($urandom);
  endtask

  // One run: reset, arm, play the sequence, let every instance finish, then
  // confirm DONE holds through a stray start. reset_at > 0 reboots mid-run.
  task automatic do_run(int len, int reset_at);
    exp_t e;
    int   last;
    run_active = 0;
    reboot_n   = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) chk_zero(k);
    @(posedge clk);
    #1 reboot_n = 1'b1;
    last = 0;
    for (int k = 0; k < NI; k++) begin
      e          = model(k, len);
      cur_exp[k] = e;
      if (int'(e.done_at) > last) last = int'(e.done_at);
      if (reset_at <= 0 || int'(e.done_at) <= reset_at) exp_q[k].push_back(e);
    end
    start = 1'b1;
    junk();
    @(posedge clk);
    #1;
    start      = 1'b0;
    run_cyc    = 0;
    run_active = 1;
    for (int i = 1; i <= last + 1; i++) begin
      if (i <= len) begin
        W_valid = sv[i];
        W_stat  = ss[i];
        W_icode = si[i];
      end else begin
        junk();
      end
      @(posedge clk);
      #1 run_cyc = i;
      if (i == reset_at) begin
        @(negedge clk);
        #1;
        run_active = 0;
        reboot_n   = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) chk_zero(k);
        return;
      end
    end
    run_active = 0;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) begin
      junk();
      @(posedge clk);
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d hold done", k), 64'(done_w[k]), 64'(1));
      chk($sformatf("u%0d hold running", k), 64'(running_w[k]), 64'(0));
      chk($sformatf("u%0d hold cycle_cnt", k), 64'(cyc_w[k]), 64'(cur_exp[k].cyc));
      chk($sformatf("u%0d hold instr_cnt", k), 64'(ins_w[k]), 64'(cur_exp[k].ins));
      chk($sformatf("u%0d hold stop_cause", k), 64'(cause_w[k]), 64'(cur_exp[k].cause));
    end
  endtask

  initial begin
    int len;
    int r;
    reboot_n = 1'b0;
    start    = 1'b0;
    W_valid  = 1'b0;
    W_stat   = 2'd0;
    W_icode  = 4'd0;
    #3;
    for (int k = 0; k < NI; k++) chk_zero(k);

    // Five retirements, two bubbles, then HLT with icode 0.
    for (int i = 1; i <= 5; i++) set_cyc(i, 1'b1, 2'd0, 4'h6);
    set_cyc(6, 1'b0, 2'd0, 4'h1);
    set_cyc(7, 1'b0, 2'd0, 4'h1);
    set_cyc(8, 1'b1, 2'd1, 4'h0);
    do_run(8, 0);

    // Long bubble stream: watchdogs expire, the disabled one waits for a fault.
    for (int i = 1; i <= 20; i++) set_cyc(i, 1'b0, 2'd0, 4'h3);
    set_cyc(21, 1'b1, 2'd2, 4'h1);
    do_run(21, 0);

    // Status fault on the same edge the 4-cycle watchdog would expire.
    for (int i = 1; i <= 3; i++) set_cyc(i, 1'b0, 2'd0, 4'h2);
    set_cyc(4, 1'b1, 2'd3, 4'hc);
    do_run(4, 0);

    // Twenty retirements saturate the 4-bit counters before an ADR fault.
    for (int i = 1; i <= 20; i++) set_cyc(i, 1'b1, 2'd0, 4'h5);
    set_cyc(21, 1'b1, 2'd2, 4'h5);
    do_run(21, 0);

    // Reboot while the 3-cycle drain instance is still draining.
    set_cyc(1, 1'b1, 2'd0, 4'h2);
    set_cyc(2, 1'b1, 2'd0, 4'h2);
    set_cyc(3, 1'b1, 2'd1, 4'h5);
    do_run(3, 4);

    // Randomised runs, each ending in a fault so every instance stops.
    for (int run = 0; run < 30; run++) begin
      len = int'($urandom_range(1, 40));
      for (int i = 1; i < len; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 60)      set_cyc(i, 1'b1, 2'd0, 4'($urandom));
        else if (r < 90) set_cyc(i, 1'b0, 2'($urandom), 4'($urandom));
        else if (r < 98) set_cyc(i, 1'b1, 2'd0, 4'($urandom));
        else             set_cyc(i, 1'b1, 2'($urandom_range(1, 3)), 4'($urandom));
      end
      set_cyc(len, 1'b1, 2'($urandom_range(1, 3)), 4'($urandom));
      do_run(len, 0);
    end

    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d pending results", k), 64'(exp_q[k].size()), 64'(0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
